bg_region_blitter: RTL and testbench
====================================

# bg_region_blitter

Parametrised successor to the full-screen background counter. It scans a rectangular region of a colour ROM in row-major order and emits pixel writes (x, y, colour, plot strobe) toward the VGA adapter. Region geometry, screen placement and ROM base address are latched on a start handshake. The block compensates a configurable ROM read latency, clips pixels that fall off-screen, can suppress a transparent colour, and reports busy and done.

## Interface
Parameters:
- X_W, 8, screen x coordinate width
- Y_W, 7, screen y coordinate width
- COLOR_W, 3, colour width
- ADDR_W, 15, ROM address width
- SCREEN_W, 160, visible columns; x ≥ SCREEN_W is clipped
- SCREEN_H, 120, visible rows; y ≥ SCREEN_H is clipped
- ROM_LATENCY, 2, cycles from rom_addr to valid rom_q; legal range 1..4

Ports:
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request a blit; sampled only in IDLE
- base_addr  in  ADDR_W  ROM address of region pixel (0,0)
- x0  in  X_W  screen x of region column 0
- y0  in  Y_W  screen y of region row 0
- width  in  X_W  region columns
- height  in  Y_W  region rows
- transparent_en  in  1  enable colour keying
- transparent_color  in  COLOR_W  key colour
- rom_addr  out  ADDR_W  ROM read address
- rom_q  in  COLOR_W  ROM data, ROM_LATENCY cycles after rom_addr
- plot_x  out  X_W  pixel x
- plot_y  out  Y_W  pixel y
- plot_color  out  COLOR_W  pixel colour; equals rom_q in the plot cycle
- plot  out  1  write strobe, one pixel per cycle
- busy  out  1  a blit is in progress
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, SCAN, DRAIN.
- IDLE, start=1: latch all region inputs and transparency inputs. If width=0 or height=0, stay in IDLE and pulse done on the next cycle. Otherwise go to SCAN with col=0, row=0 and rom_addr=base_addr.
- SCAN: issue one pixel per cycle. rom_addr increments by 1 each cycle using a running counter; no multiplier. The address for (row, col) is base_addr + row·width + col, modulo 2^ADDR_W.
  - col counts up to width−1, then returns to 0 and row increments.
  - After the pixel (height−1, width−1) is issued, go to DRAIN.
- Pipeline: a ROM_LATENCY-deep shift register carries, for each issued pixel, valid, sx = x0+col and sy = y0+row. The sums are computed one bit wider than X_W / Y_W.
- Output stage, when the pipeline's final stage is valid:
  - plot_x = sx[X_W−1:0] and plot_y = sy[Y_W−1:0].
  - plot=1 unless sx ≥ SCREEN_W, or sy ≥ SCREEN_H, or (transparent_en and rom_q == transparent_color).
  - Suppressed pixels still consume their cycle.
- DRAIN: wait until the pipeline is empty, then return to IDLE and pulse done.
- start is ignored while the FSM is in SCAN or DRAIN. Input changes after start have no effect on the blit in progress.
- A start in the done cycle is accepted, because the FSM is already in IDLE.
- Reset at any time:
  - FSM returns to IDLE and all pipeline valids clear.
  - Outputs go to 0: rom_addr, plot_x, plot_y, plot_color, plot, busy, done.
  - An aborted blit produces no done pulse and no further plots.

## Timing
- Let start be accepted in cycle N, let L = ROM_LATENCY and P = width·height.
- busy is high from N+1 through N+P+L inclusive.
- Pixel k (k = 0..P−1) drives rom_addr in cycle N+1+k, and its plot cycle is N+1+k+L.
- done is high in cycle N+P+L+1 only, with busy=0 in that cycle.
- Zero-size blit: busy stays 0 and done is high in N+1.
- Throughput is 1 pixel per cycle with no bubbles across row wrap.
- plot_x, plot_y and plot_color are valid only when plot=1.

## Test plan
- Full screen: base=0, x0=y0=0, 160×120, L=2. Expect 19200 plots in raster order, rom_addr running 0..19199, plot colour equal to ROM contents, and done at N+19203.
- Small region: base=100, x0=10, y0=20, 4×3. Expect rom_addr 100..111 and plots (10..13, 20..22) row-major, each colour matching its address. Repeat with L=1 and L=4 and check the shifted timing.
- Clipping: x0=156, y0=118, 8×4. Expect only cols 0..3 of rows 0..1 to plot (8 plots), 32 cycles of scanning, and done at N+32+L+1.
- Transparency: ROM region holding the pattern 0,5,5,2 with transparent_en=1 and key=5. Expect plots only for colours 0 and 2; with transparent_en=0, expect all 4 plots.
- Zero size and busy start: width=0 → done at N+1 with no plots. A start pulsed mid-scan is ignored and produces no second done. A start in the done cycle launches a new blit.
- Reset mid-scan: assert reset at pixel 50 of 160×120. Expect all outputs 0 on the next cycle, no further plot, and no done. The next start runs a clean blit from base_addr.

Source files
------------

// File: rtl/bg_region_blitter.sv
// bg_region_blitter: scans a rectangular colour-ROM region row-major and
// emits clipped, colour-keyed pixel writes with ROM latency compensation.
module bg_region_blitter #(
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int COLOR_W     = 3,
    parameter int ADDR_W      = 15,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int ROM_LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [X_W-1:0]     x0,
    input  logic [Y_W-1:0]     y0,
    input  logic [X_W-1:0]     width,
    input  logic [Y_W-1:0]     height,
    input  logic               transparent_en,
    input  logic [COLOR_W-1:0] transparent_color,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_q,
    output logic [X_W-1:0]     plot_x,
    output logic [Y_W-1:0]     plot_y,
    output logic [COLOR_W-1:0] plot_color,
    output logic               plot,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    localparam logic [X_W:0] X_LIM = SCREEN_W[X_W:0];
    localparam logic [Y_W:0] Y_LIM = SCREEN_H[Y_W:0];

    state_t               r_state;
    state_t               w_next;
    logic [X_W-1:0]       r_x0;
    logic [Y_W-1:0]       r_y0;
    logic [X_W-1:0]       r_w;
    logic [Y_W-1:0]       r_h;
    logic                 r_ten;
    logic [COLOR_W-1:0]   r_key;
    logic [X_W-1:0]       r_col;
    logic [Y_W-1:0]       r_row;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_done;
    logic [ROM_LATENCY-1:0] r_vld;
    logic [X_W:0]         r_sx [ROM_LATENCY];
    logic [Y_W:0]         r_sy [ROM_LATENCY];

    logic                 w_zero;
    logic                 w_last_col;
    logic                 w_last;
    logic                 w_upstream;
    logic                 w_done_nxt;
    logic                 w_fin;
    logic [X_W:0]         w_sx;
    logic [Y_W:0]         w_sy;
    logic                 w_key_hit;

    assign w_zero     = (width == '0) || (height == '0);
    assign w_last_col = (r_col == r_w - X_W'(1));
    assign w_last     = w_last_col && (r_row == r_h - Y_W'(1));

    // Any valid pixel ahead of the final stage keeps DRAIN alive.
    always_comb begin
        w_upstream = 1'b0;
        for (int i = 0; i < ROM_LATENCY - 1; i++) begin
            w_upstream = w_upstream | r_vld[i];
        end
    end

    always_comb begin
        w_next     = r_state;
        w_done_nxt = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_zero) w_done_nxt = 1'b1;
                    else        w_next     = SCAN;
                end
            end
            SCAN: begin
                if (w_last) w_next = DRAIN;
            end
            DRAIN: begin
                if (!w_upstream) begin
                    w_next     = IDLE;
                    w_done_nxt = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x0   <= '0;
            r_y0   <= '0;
            r_w    <= '0;
            r_h    <= '0;
            r_ten  <= 1'b0;
            r_key  <= '0;
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
            r_done <= 1'b0;
            r_vld  <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                r_sx[i] <= '0;
                r_sy[i] <= '0;
            end
        end else begin
            r_done <= w_done_nxt;
            if (r_state == IDLE && start) begin
                r_x0   <= x0;
                r_y0   <= y0;
                r_w    <= width;
                r_h    <= height;
                r_ten  <= transparent_en;
                r_key  <= transparent_color;
                r_col  <= '0;
                r_row  <= '0;
                r_addr <= base_addr;
            end else if (r_state == SCAN) begin
                // Running address: row wrap needs no multiply.
                r_addr <= r_addr + ADDR_W'(1);
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= r_row + Y_W'(1);
                end else begin
                    r_col <= r_col + X_W'(1);
                end
            end
            r_vld[0] <= (r_state == SCAN);
            r_sx[0]  <= {1'b0, r_x0} + {1'b0, r_col};
            r_sy[0]  <= {1'b0, r_y0} + {1'b0, r_row};
            for (int i = 1; i < ROM_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_sx[i]  <= r_sx[i-1];
                r_sy[i]  <= r_sy[i-1];
            end
        end
    end

    assign w_fin     = r_vld[ROM_LATENCY-1];
    assign w_sx      = r_sx[ROM_LATENCY-1];
    assign w_sy      = r_sy[ROM_LATENCY-1];
    assign w_key_hit = r_ten && (rom_q == r_key);

    assign plot       = w_fin && (w_sx < X_LIM) && (w_sy < Y_LIM) && !w_key_hit;
    assign plot_x     = w_fin ? w_sx[X_W-1:0] : '0;
    assign plot_y     = w_fin ? w_sy[Y_W-1:0] : '0;
    assign plot_color = w_fin ? rom_q : '0;
    assign rom_addr   = r_addr;
    assign busy       = (r_state != IDLE);
    assign done       = r_done;

endmodule

// File: tb/tb_bg_region_blitter.sv
// Bench for bg_region_blitter: three latency variants share stimulus and
// are compared every cycle against a per-blit event reference model.
module tb_bg_region_blitter;

    localparam int NI = 3;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [14:0] base_addr;
    logic [7:0]  x0;
    logic [6:0]  y0;
    logic [7:0]  width;
    logic [6:0]  height;
    logic        ten;
    logic [2:0]  tkey;

    logic [14:0] w_addr [NI];
    logic [2:0]  w_q    [NI];
    logic [7:0]  w_px   [NI];
    logic [6:0]  w_py   [NI];
    logic [2:0]  w_pc   [NI];
    logic        w_plot [NI];
    logic        w_busy [NI];
    logic        w_done [NI];

    logic [2:0]  rom [32768];

    int cyc = 0;
    int n_err = 0;
    int n_chk = 0;
    int rst_chk = -1;
    int busy_lo [NI];
    int busy_hi [NI];
    int done_at [NI];
    int free_at [NI];
    pix_t        e_pix  [int];
    logic [14:0] e_addr [int];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        logic [2:0] pipe [LAT];
        always @(posedge clk) begin
            pipe[0] <= rom[w_addr[g]];
            for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
        end
        assign w_q[g] = pipe[LAT-1];
        bg_region_blitter #(.ROM_LATENCY(LAT)) u_dut (
            .clk(clk), .reset(reset), .start(start),
            .base_addr(base_addr), .x0(x0), .y0(y0),
            .width(width), .height(height),
            .transparent_en(ten), .transparent_color(tkey),
            .rom_addr(w_addr[g]), .rom_q(w_q[g]),
            .plot_x(w_px[g]), .plot_y(w_py[g]), .plot_color(w_pc[g]),
            .plot(w_plot[g]), .busy(w_busy[g]), .done(w_done[g])
        );
    end

    function automatic int lat_of(int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    endfunction

    function automatic int max_free();
        int m = 0;
        for (int i = 0; i < NI; i++) if (free_at[i] > m) m = free_at[i];
        return m;
    endfunction

    task automatic chk(input string tag, input int inst,
                       input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h exp=%0h",
                     tag, inst, cyc, got, exp);
        end
    endtask

    // Start accepted at the edge ending cycle n: derive every event it causes.
    task automatic model_start(int i, int n);
        int l = lat_of(i);
        int p = int'(width) * int'(height);
        busy_lo[i] = 0;
        busy_hi[i] = -1;
        if (p == 0) begin
            done_at[i] = n + 1;
            free_at[i] = n + 1;
            return;
        end
        for (int k = 0; k < p; k++) begin
            int col = k % int'(width);
            int row = k / int'(width);
            int sx = int'(x0) + col;
            int sy = int'(y0) + row;
            logic [14:0] a = base_addr + 15'(k);
            logic [2:0] c = rom[a];
            e_addr[(n + 1 + k) * 4 + i] = a;
            if (sx < 160 && sy < 120 && !(ten && c == tkey)) begin
                pix_t px;
                px.x = 8'(sx);
                px.y = 7'(sy);
                px.c = c;
                e_pix[(n + 1 + k + l) * 4 + i] = px;
            end
        end
        busy_lo[i] = n + 1;
        busy_hi[i] = n + p + l;
        done_at[i] = n + p + l + 1;
        free_at[i] = n + p + l + 1;
    endtask

    task automatic model_edge();
        int dead[$];
        if (reset) begin
            foreach (e_pix[k]) if (k >= (cyc + 1) * 4) dead.push_back(k);
            foreach (dead[j]) e_pix.delete(dead[j]);
            dead.delete();
            foreach (e_addr[k]) if (k >= (cyc + 1) * 4) dead.push_back(k);
            foreach (dead[j]) e_addr.delete(dead[j]);
            for (int i = 0; i < NI; i++) begin
                busy_lo[i] = 0;
                busy_hi[i] = -1;
                done_at[i] = -1;
                free_at[i] = cyc + 1;
            end
            rst_chk = cyc + 1;
        end else if (start) begin
            for (int i = 0; i < NI; i++)
                if (cyc >= free_at[i]) model_start(i, cyc);
        end
    endtask

    task automatic check_cycle();
        for (int i = 0; i < NI; i++) begin
            int key = cyc * 4 + i;
            logic ep = e_pix.exists(key);
            if (rst_chk == cyc) begin
                chk("rst_addr", i, 32'(w_addr[i]), 0);
                chk("rst_x", i, 32'(w_px[i]), 0);
                chk("rst_y", i, 32'(w_py[i]), 0);
                chk("rst_col", i, 32'(w_pc[i]), 0);
            end
            if (e_addr.exists(key)) begin
                chk("addr", i, 32'(w_addr[i]), 32'(e_addr[key]));
                e_addr.delete(key);
            end
            chk("plot", i, 32'(w_plot[i]), 32'(ep));
            if (ep) begin
                if (w_plot[i]) begin
                    chk("px", i, 32'(w_px[i]), 32'(e_pix[key].x));
                    chk("py", i, 32'(w_py[i]), 32'(e_pix[key].y));
                    chk("pc", i, 32'(w_pc[i]), 32'(e_pix[key].c));
                end
                e_pix.delete(key);
            end
            chk("busy", i, 32'(w_busy[i]),
                32'(cyc >= busy_lo[i] && cyc <= busy_hi[i]));
            chk("done", i, 32'(w_done[i]), 32'(cyc == done_at[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic scramble();
        base_addr = 15'($urandom);
        x0        = 8'($urandom);
        y0        = 7'($urandom);
        width     = 8'($urandom);
        height    = 7'($urandom);
        ten       = 1'($urandom);
        tkey      = 3'($urandom);
    endtask

    task automatic blit(int b, int x, int y, int w, int h, int te, int key);
        base_addr = 15'(b);
        x0        = 8'(x);
        y0        = 7'(y);
        width     = 8'(w);
        height    = 7'(h);
        ten       = 1'(te);
        tkey      = 3'(key);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        scramble();
    endtask

    task automatic wait_idle();
        int lim = cyc + 40000;
        while (cyc < max_free()) begin
            tick();
            if (cyc > lim) begin
                n_chk++;
                n_err++;
                $display("FAIL idle_timeout cyc=%0d", cyc);
                break;
            end
        end
        tick();
    endtask

    initial begin
        for (int a = 0; a < 32768; a++) rom[a] = 3'($urandom);
        rom[200] = 3'd0;
        rom[201] = 3'd5;
        rom[202] = 3'd5;
        rom[203] = 3'd2;
        for (int i = 0; i < NI; i++) begin
            busy_lo[i] = 0;
            busy_hi[i] = -1;
            done_at[i] = -1;
            free_at[i] = 0;
        end
        reset = 1'b1;
        start = 1'b0;
        scramble();
        tick();
        tick();
        reset = 1'b0;
        tick();

        blit(100, 10, 20, 4, 3, 0, 0);
        wait_idle();
        blit(1234, 156, 118, 8, 4, 0, 0);
        wait_idle();
        blit(200, 0, 0, 4, 1, 1, 5);
        wait_idle();
        blit(200, 0, 0, 4, 1, 0, 5);
        wait_idle();
        blit(300, 5, 5, 0, 3, 0, 0);
        wait_idle();
        blit(300, 5, 5, 3, 0, 0, 0);
        tick();

        blit(500, 30, 40, 6, 3, 0, 0);
        tick();
        tick();
        blit(900, 0, 0, 2, 2, 0, 0);
        while (cyc < done_at[1]) tick();
        blit(700, 50, 60, 3, 2, 0, 0);
        wait_idle();

        blit(0, 0, 0, 160, 120, 0, 0);
        wait_idle();

        blit(4000, 0, 0, 160, 120, 0, 0);
        for (int k = 0; k < 50; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        blit(4000, 3, 4, 5, 2, 0, 0);
        wait_idle();

        for (int t = 0; t < 30; t++) begin
            int xs = ($urandom_range(0, 1) == 1) ? $urandom_range(150, 170)
                                                  : $urandom_range(0, 255);
            blit($urandom, xs, $urandom_range(0, 127),
                 $urandom_range(0, 12), $urandom_range(0, 6),
                 $urandom_range(0, 1), $urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) begin
                for (int k = 0; k < 3; k++) tick();
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            wait_idle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
